l1_mem_responder: RTL

//  Memory-side responder for the L1 instruction-cache memory request interface.
//  - Accepts one line/uncached read request at a time from an L1 initiator.
//  - Splits it into 64-bit word reads on a simple backing-store port.
//  - Assembles the beats into one L1 line and returns it with a single-cycle

---
 rtl/l1_mem_responder_pkg.sv | 52 +++++
 rtl/l1_mem_responder.sv | 113 +++++++++++
 2 files changed

// File: rtl/l1_mem_responder_pkg.sv
// Shared types and constants for the L1 memory-side responder.
// Holds the FSM encoding, register set, reset value and beat-count helper.
package l1_mem_responder_pkg;

    localparam int unsigned CFG_CPU_ADDR_BITS      = 32;
    localparam int unsigned L1CACHE_BYTES_PER_LINE = 32;
    localparam int unsigned L1CACHE_LINE_BITS      = 8 * L1CACHE_BYTES_PER_LINE;
    localparam int unsigned REQ_MEM_TYPE_BITS      = 3;
    localparam int unsigned REQ_MEM_TYPE_WRITE     = 0;
    localparam int unsigned REQ_MEM_TYPE_CACHED    = 1;
    localparam int unsigned REQ_MEM_TYPE_UNIQUE    = 2;
    localparam int unsigned WORD_BITS              = 64;

    localparam logic [1:0] Idle     = 2'd0;
    localparam logic [1:0] WordReq  = 2'd1;
    localparam logic [1:0] WordResp = 2'd2;
    localparam logic [1:0] Resp     = 2'd3;

    typedef struct packed {
        logic [1:0]                         state;
        logic [CFG_CPU_ADDR_BITS-1:0]       base;
        logic [1:0]                         beat_cnt;
        logic [1:0]                         nbeats_m1;
        logic                               is_wr;
        logic                               fault;
        logic [L1CACHE_LINE_BITS-1:0]       line_buf;
    } l1_mem_responder_registers;

    localparam l1_mem_responder_registers l1_mem_responder_r_reset = '{
        state:     Idle,
        base:      '0,
        beat_cnt:  2'd0,
        nbeats_m1: 2'd0,
        is_wr:     1'b0,
        fault:     1'b0,
        line_buf:  '0
    };

    // Number of 64-bit beats minus one; sizes of 8 bytes or less take one beat,
    // anything of a line or larger is clamped to four.
    function automatic logic [1:0] beats_m1(input logic [2:0] size);
        logic [1:0] res;
        res = 2'd0;
        if (size >= 3'd5) begin
            res = 2'd3;
        end else if (size == 3'd4) begin
            res = 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/l1_mem_responder.sv
// Memory-side responder for the L1 request interface: splits one request into
// 64-bit backing-store reads and returns the assembled line in a single pulse.
module l1_mem_responder
    import l1_mem_responder_pkg::*;
#(
    parameter int unsigned abits       = CFG_CPU_ADDR_BITS,
    parameter int unsigned lnbytes     = L1CACHE_BYTES_PER_LINE,
    parameter bit          wr_fault    = 1'b1,
    parameter bit          async_reset = 1'b1
) (
    input  logic                          i_clk,
    input  logic                          i_nrst,
    input  logic                          i_req_mem_valid,
    output logic                          o_req_mem_ready,
    input  logic [REQ_MEM_TYPE_BITS-1:0]  i_req_mem_type,
    input  logic [2:0]                    i_req_mem_size,
    input  logic [abits-1:0]              i_req_mem_addr,
    input  logic [lnbytes-1:0]            i_req_mem_strob,
    input  logic [8*lnbytes-1:0]          i_req_mem_data,
    output logic                          o_mem_data_valid,
    output logic [8*lnbytes-1:0]          o_mem_data,
    output logic                          o_mem_load_fault,
    output logic                          o_word_req_valid,
    input  logic                          i_word_req_ready,
    output logic [abits-1:0]              o_word_addr,
    input  logic                          i_word_resp_valid,
    input  logic [WORD_BITS-1:0]          i_word_resp_data,
    input  logic                          i_word_resp_err
);

    l1_mem_responder_registers r;
    l1_mem_responder_registers rin;

    // Write payload, strobes and sub-word address bits play no part in a read.
    logic unused_c;
    assign unused_c = ^{i_req_mem_strob, i_req_mem_data, i_req_mem_addr[2:0],
                        i_req_mem_type[REQ_MEM_TYPE_BITS-1:1], r.is_wr};

    // Next-state logic
    always_comb begin
        rin = r;
        case (r.state)
            Idle: begin
                if (i_req_mem_valid) begin
                    rin.base      = CFG_CPU_ADDR_BITS'({i_req_mem_addr[abits-1:3], 3'b000});
                    rin.nbeats_m1 = beats_m1(i_req_mem_size);
                    rin.is_wr     = i_req_mem_type[REQ_MEM_TYPE_WRITE];
                    rin.line_buf  = '0;
                    rin.beat_cnt  = 2'd0;
                    rin.fault     = 1'b0;
                    if (i_req_mem_type[REQ_MEM_TYPE_WRITE]) begin
                        rin.fault = wr_fault;
                        rin.state = Resp;
                    end else begin
                        rin.state = WordReq;
                    end
                end
            end
            WordReq: begin
                if (i_word_req_ready) begin
                    rin.state = WordResp;
                end
            end
            WordResp: begin
                if (i_word_resp_valid) begin
                    rin.line_buf[{r.beat_cnt, 6'd0} +: WORD_BITS] = i_word_resp_data;
                    rin.fault = r.fault | i_word_resp_err;
                    if (r.beat_cnt == r.nbeats_m1) begin
                        rin.state = Resp;
                    end else begin
                        rin.beat_cnt = r.beat_cnt + 2'd1;
                        rin.state    = WordReq;
                    end
                end
            end
            Resp: begin
                rin.state = Idle;
            end
            default: begin
                rin.state = Idle;
            end
        endcase
    end

    // Outputs are decoded from registered state only.
    assign o_req_mem_ready  = (r.state == Idle);
    assign o_mem_data_valid = (r.state == Resp);
    assign o_mem_data       = (8*lnbytes)'(r.line_buf);
    assign o_mem_load_fault = (r.state == Resp) & r.fault;
    assign o_word_req_valid = (r.state == WordReq);
    assign o_word_addr      = abits'(r.base + CFG_CPU_ADDR_BITS'({r.beat_cnt, 3'b000}));

    generate
        if (async_reset) begin : g_async_rst
            always_ff @(posedge i_clk or negedge i_nrst) begin
                if (!i_nrst) begin
                    r <= l1_mem_responder_r_reset;
                end else begin
                    r <= rin;
                end
            end
        end else begin : g_sync_rst
            always_ff @(posedge i_clk) begin
                if (!i_nrst) begin
                    r <= l1_mem_responder_r_reset;
                end else begin
                    r <= rin;
                end
            end
        end
    endgenerate

endmodule
